spi_segment_scan_controller: RTL and testbench

Parametrised SPI-programmed, time-multiplexed multi-digit 7-segment driver. It is the successor to the single-digit pass-through segment top. An SPI master writes per-digit segment patterns, a blink mask and a global enable into a register file. The block then scans the digits round-robin at a programmable refresh rate. It sits behind the tile top, with SPI pins on `ui_in`/`uio_in` and `seg_out`/`dig_out` on `uo_out`/`uio_out`.

---
 rtl/spi_seg_pkg.sv | 20 ++
 rtl/spi_frame_rx.sv | 70 +++++++
 rtl/spi_segment_scan_controller.sv | 149 ++++++++++++++
 tb/tb_spi_segment_scan_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seg_pkg.sv
// Shared constants for the SPI-programmed segment scan controller:
// frame geometry, command codes and field positions.
package spi_seg_pkg;

    localparam int FRAME_W     = 16;
    localparam int BIT_CNT_MAX = FRAME_W + 1;

    localparam int CMD_HI  = 15;
    localparam int CMD_LO  = 12;
    localparam int ADDR_HI = 11;
    localparam int ADDR_LO = 8;
    localparam int DATA_HI = 7;
    localparam int DATA_LO = 0;

    localparam logic [3:0] CMD_NOP         = 4'h0;
    localparam logic [3:0] CMD_WRITE_DIGIT = 4'h1;
    localparam logic [3:0] CMD_SET_BLINK   = 4'h2;
    localparam logic [3:0] CMD_SET_ENABLE  = 4'h3;

endpackage

// File: rtl/spi_frame_rx.sv
// SPI mode-0 frame receiver: synchronises the pins, shifts MSB-first bits
// and reports each completed frame on the cs_n rising edge.
module spi_frame_rx
    import spi_seg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               sclk,
    input  logic               cs_n,
    input  logic               mosi,
    output logic               frame_valid,
    output logic               frame_len_ok,
    output logic [FRAME_W-1:0] frame
);

    logic [1:0]         r_sclk_sync;
    logic [1:0]         r_cs_sync;
    logic [1:0]         r_mosi_sync;
    logic               r_sclk_prev;
    logic               r_cs_prev;
    logic               r_armed;
    logic [4:0]         r_bit_cnt;
    logic [FRAME_W-1:0] r_shift;

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_cs_rise;

    assign w_sclk      = r_sclk_sync[1];
    assign w_cs        = r_cs_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_cs_rise   = w_cs & ~r_cs_prev;

    // A frame counts only if the receiver saw cs_n idle before it started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
            r_armed     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_cs_sync   <= {r_cs_sync[0], cs_n};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
            if (w_cs) begin
                r_armed   <= 1'b1;
                r_bit_cnt <= '0;
            end else if (r_armed && w_sclk_rise) begin
                r_shift <= {r_shift[FRAME_W-2:0], w_mosi};
                if (r_bit_cnt != 5'(BIT_CNT_MAX)) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
        end
    end

    assign frame_valid  = w_cs_rise & r_armed;
    assign frame_len_ok = (r_bit_cnt == 5'(FRAME_W));
    assign frame        = r_shift;

endmodule

// File: rtl/spi_segment_scan_controller.sv
// Time-multiplexed multi-digit 7-segment driver with an SPI-written register
// file holding digit patterns, a blink mask and a global enable.
module spi_segment_scan_controller
    import spi_seg_pkg::*;
#(
    parameter int          N_DIGITS    = 4,
    parameter int          SEG_W       = 8,
    parameter logic [23:0] REFRESH_DIV = 24'd10_000,
    parameter int          BLINK_SCANS = 64,
    parameter int          ACTIVE_LOW  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic [SEG_W-1:0]    seg_out,
    output logic [N_DIGITS-1:0] dig_out,
    output logic                frame_err
);

    localparam int          IDX_W    = $clog2(N_DIGITS);
    localparam int          BC_W     = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic        POL      = (ACTIVE_LOW != 0);
    localparam logic [23:0] DIV_LAST = REFRESH_DIV - 24'd1;

    logic               w_frame_valid;
    logic               w_frame_len_ok;
    logic [FRAME_W-1:0] w_frame;
    logic [3:0]         w_cmd;
    logic [3:0]         w_addr;
    logic [7:0]         w_data;
    logic [IDX_W-1:0]   w_addr_idx;
    logic               w_cmd_ok;
    logic               w_accept;
    logic               w_slot_end;
    logic               w_scan_end;
    logic [SEG_W-1:0]   w_pattern;
    logic [N_DIGITS-1:0] w_onehot;

    logic [SEG_W-1:0]    r_digit [N_DIGITS];
    logic [N_DIGITS-1:0] r_blink_mask;
    logic                r_enable;
    logic                r_blink_phase;
    logic [23:0]         r_div_cnt;
    logic [IDX_W-1:0]    r_scan_idx;
    logic [BC_W-1:0]     r_blink_cnt;
    logic [SEG_W-1:0]    r_seg_out;
    logic [N_DIGITS-1:0] r_dig_out;
    logic                r_frame_err;

    spi_frame_rx u_rx (
        .clk          (clk),
        .rst          (rst),
        .sclk         (sclk),
        .cs_n         (cs_n),
        .mosi         (mosi),
        .frame_valid  (w_frame_valid),
        .frame_len_ok (w_frame_len_ok),
        .frame        (w_frame)
    );

    assign w_cmd      = w_frame[CMD_HI:CMD_LO];
    assign w_addr     = w_frame[ADDR_HI:ADDR_LO];
    assign w_data     = w_frame[DATA_HI:DATA_LO];
    assign w_addr_idx = w_addr[IDX_W-1:0];

    always_comb begin
        w_cmd_ok = 1'b0;
        case (w_cmd)
            CMD_NOP, CMD_SET_BLINK, CMD_SET_ENABLE: w_cmd_ok = 1'b1;
            CMD_WRITE_DIGIT:                        w_cmd_ok = (int'(w_addr) < N_DIGITS);
            default:                                w_cmd_ok = 1'b0;
        endcase
    end

    assign w_accept = w_frame_valid & w_frame_len_ok & w_cmd_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                r_digit[i] <= '0;
            end
            r_blink_mask <= '0;
            r_enable     <= 1'b1;
            r_frame_err  <= 1'b0;
        end else begin
            r_frame_err <= w_frame_valid & ~w_accept;
            if (w_accept) begin
                case (w_cmd)
                    CMD_WRITE_DIGIT: r_digit[w_addr_idx] <= w_data[SEG_W-1:0];
                    CMD_SET_BLINK:   r_blink_mask        <= w_data[N_DIGITS-1:0];
                    CMD_SET_ENABLE:  r_enable            <= w_data[0];
                    default:         ;
                endcase
            end
        end
    end

    assign w_slot_end = (r_div_cnt == DIV_LAST);
    assign w_scan_end = w_slot_end && (r_scan_idx == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt     <= '0;
            r_scan_idx    <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_div_cnt  <= '0;
                r_scan_idx <= w_scan_end ? '0 : r_scan_idx + 1'b1;
            end else begin
                r_div_cnt <= r_div_cnt + 24'd1;
            end
            if (w_scan_end) begin
                if (r_blink_cnt == BC_W'(BLINK_SCANS - 1)) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_onehot
        assign w_onehot[gi] = (r_scan_idx == IDX_W'(gi));
    end

    assign w_pattern = (!r_enable || (r_blink_mask[r_scan_idx] && r_blink_phase))
                       ? '0 : r_digit[r_scan_idx];

    // Segment and digit selects update on the same edge, so no ghost cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_out <= {SEG_W{POL}};
            r_dig_out <= N_DIGITS'(1) ^ {N_DIGITS{POL}};
        end else begin
            r_seg_out <= w_pattern ^ {SEG_W{POL}};
            r_dig_out <= w_onehot ^ {N_DIGITS{POL}};
        end
    end

    assign seg_out   = r_seg_out;
    assign dig_out   = r_dig_out;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_segment_scan_controller.sv
// Bench for the segment scan controller: drives SPI frames into an
// active-high and an active-low instance and checks both against a model.
module tb_spi_segment_scan_controller;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int D  = 8;
    localparam int BS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;

    logic [SW-1:0] seg0, seg1;
    logic [N-1:0]  dig0, dig1;
    logic          err0, err1;

    spi_segment_scan_controller #(
        .N_DIGITS(N), .SEG_W(SW), .REFRESH_DIV(24'(D)), .BLINK_SCANS(BS), .ACTIVE_LOW(0)
    ) dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .seg_out(seg0), .dig_out(dig0), .frame_err(err0)
    );

    spi_segment_scan_controller #(
        .N_DIGITS(N), .SEG_W(SW), .REFRESH_DIV(24'(D)), .BLINK_SCANS(BS), .ACTIVE_LOW(1)
    ) dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .seg_out(seg1), .dig_out(dig1), .frame_err(err1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ecnt0 = 0;
    int ecnt1 = 0;

    // cyc = number of active edges since the last reset edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (err0) ecnt0 <= ecnt0 + 1;
        if (err1) ecnt1 <= ecnt1 + 1;
    end

    logic [SW-1:0] m_dig [N];
    logic [N-1:0]  m_mask;
    logic          m_en;

    int           err_q  [$];
    logic [23:0]  scan_q [$];

    function automatic logic [23:0] model_out(input int k);
        int m, idx, ph;
        logic [SW-1:0] p;
        logic [N-1:0]  oh;
        m   = (k == 0) ? 0 : k - 1;
        idx = (m / D) % N;
        ph  = ((m / (D * N)) / BS) % 2;
        p   = (!m_en || (m_mask[idx] && ph == 1)) ? 8'h00 : m_dig[idx];
        oh  = 4'b0001 << idx;
        return {p, oh, ~p, ~oh};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = '0;
        m_mask = '0;
        m_en   = 1'b1;
    endtask

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n, input int exp_err);
        cs_n = 1'b0;
        half();
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
        half();
        cs_n = 1'b1;
        err_q.push_back(exp_err);
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input int exp_err, input string name);
        int b0, b1, e;
        b0 = ecnt0;
        b1 = ecnt1;
        send_bits(bits, n, exp_err);
        repeat (12) @(negedge clk);
        e = err_q.pop_front();
        total++;
        if ((ecnt0 - b0) !== e) begin
            bad++;
            $display("FAIL err_%s: got %0d pulses, want %0d", name, ecnt0 - b0, e);
        end
        total++;
        if ((ecnt1 - b1) !== e) begin
            bad++;
            $display("FAIL err_inv_%s: got %0d pulses, want %0d", name, ecnt1 - b1, e);
        end
    endtask

    task automatic sample_scan(input int n, input string name);
        logic [23:0] exp;
        repeat (n) begin
            @(negedge clk);
            scan_q.push_back(model_out(cyc));
            exp = scan_q.pop_front();
            total++;
            if ({seg0, dig0, seg1, dig1} !== exp) begin
                bad++;
                $display("FAIL scan_%s cyc=%0d: got seg=%h dig=%b iseg=%h idig=%b, want seg=%h dig=%b iseg=%h idig=%b",
                         name, cyc, seg0, dig0, seg1, dig1, exp[23:16], exp[15:12], exp[11:4], exp[3:0]);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({seg0, dig0} !== 12'h001) begin
            bad++;
            $display("FAIL reset_out: got seg=%h dig=%b, want seg=00 dig=0001", seg0, dig0);
        end
        total++;
        if ({seg1, dig1} !== 12'hFFE) begin
            bad++;
            $display("FAIL reset_out_inv: got seg=%h dig=%b, want seg=ff dig=1110", seg1, dig1);
        end
        total++;
        if ({err0, err1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_err: got %b, want 00", {err0, err1});
        end
        sample_scan(2 * N * D + 4, "reset");
    endtask

    task automatic test_write();
        frame(32'h125B, 16, 0, "write");
        m_dig[2] = 8'h5B;
        frame(32'h0000, 16, 0, "nop");
        sample_scan(N * D + 8, "write");
    endtask

    task automatic test_back_to_back();
        int b0, e;
        b0 = ecnt0;
        send_bits(32'h103F, 16, 0);
        repeat (3) @(negedge clk);
        send_bits(32'h134F, 16, 0);
        repeat (3) @(negedge clk);
        send_bits(32'h1106, 16, 0);
        repeat (12) @(negedge clk);
        e = err_q.pop_front() + err_q.pop_front() + err_q.pop_front();
        total++;
        if ((ecnt0 - b0) !== e) begin
            bad++;
            $display("FAIL err_b2b: got %0d pulses, want %0d", ecnt0 - b0, e);
        end
        m_dig[0] = 8'h3F;
        m_dig[3] = 8'h4F;
        m_dig[1] = 8'h06;
        sample_scan(N * D + 8, "b2b");
    endtask

    task automatic test_bad_frames();
        frame(32'h0000_11FF, 15, 1, "len15");
        frame(32'h0001_10AA, 17, 1, "len17");
        frame(32'h0000_17FF, 16, 1, "addr7");
        frame(32'h0000_9000, 16, 1, "cmd9");
        sample_scan(N * D + 8, "bad");
    endtask

    task automatic test_blink();
        frame(32'h2001, 16, 0, "blink");
        m_mask = 4'b0001;
        sample_scan(2 * N * D * BS + 20, "blink");
    endtask

    task automatic test_enable();
        frame(32'h3000, 16, 0, "disable");
        m_en = 1'b0;
        sample_scan(N * D + 8, "disabled");
        frame(32'h3001, 16, 0, "enable");
        m_en = 1'b1;
        sample_scan(N * D + 8, "enabled");
    endtask

    task automatic test_reset_midframe();
        int b0;
        logic [15:0] f;
        f  = 16'h1177;
        b0 = ecnt0;
        cs_n = 1'b0;
        half();
        for (int i = 15; i >= 8; i--) begin
            mosi = f[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
        apply_reset();
        for (int i = 7; i >= 0; i--) begin
            mosi = f[i];
            half();
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
        half();
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if ((ecnt0 - b0) !== 0) begin
            bad++;
            $display("FAIL err_midframe: got %0d pulses, want 0", ecnt0 - b0);
        end
        sample_scan(N * D + 8, "midframe");
        frame(32'h1122, 16, 0, "after_rst");
        m_dig[1] = 8'h22;
        sample_scan(N * D + 8, "after_rst");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write();
        test_back_to_back();
        test_bad_frames();
        test_blink();
        test_enable();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
